// File: rtl/parallel_serial_slave.sv
// Slave end of the chip-select/clock/data serial link: receives a DATA_WIDTH-bit
// word MSB-first from the initiator and returns tx_data MSB-first on ser_data_out.
module parallel_serial_slave #(
  parameter int unsigned DATA_WIDTH = 171
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ser_clk,
  input  logic                  ser_cs,
  input  logic                  ser_data_in,
  output logic                  ser_data_out,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int unsigned CNT_W = $clog2(DATA_WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    WAIT_CS = 2'd2
  } state_t;

  // [0],[1] synchroniser stages, [2] history for edge detection
  logic [2:0]            r_clk_sync;
  logic [2:0]            r_cs_sync;
  logic [1:0]            r_din_sync;
  logic                  r_flushed;
  logic                  r_cs_armed;
  state_t                r_state;
  logic [CNT_W-1:0]      r_bit_cnt;
  logic [DATA_WIDTH-1:0] r_tx_shift;
  logic [DATA_WIDTH-1:0] r_rx_shift;
  logic                  r_rx_done;

  logic                  w_clk_fall;
  logic                  w_cs_s;
  logic                  w_cs_fall;
  logic                  w_cs_rise;
  logic                  w_din_s;
  logic                  w_cnt_last;
  state_t                w_state_nxt;
  logic                  w_start;
  logic                  w_shift;
  logic                  w_last;
  logic                  w_err;
  logic                  w_busy_nxt;

  assign w_clk_fall = r_clk_sync[2] & ~r_clk_sync[1];
  assign w_cs_s     = r_cs_sync[1];
  assign w_cs_fall  = r_cs_sync[2] & ~w_cs_s;
  assign w_cs_rise  = ~r_cs_sync[2] & w_cs_s;
  assign w_din_s    = r_din_sync[1];
  assign w_cnt_last = (r_bit_cnt == CNT_W'(DATA_WIDTH - 1));

  // Bring the asynchronous serial inputs into the clk domain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clk_sync <= 3'b000;
      r_cs_sync  <= 3'b111;
      r_din_sync <= 2'b00;
    end else begin
      r_clk_sync <= {r_clk_sync[1:0], ser_clk};
      r_cs_sync  <= {r_cs_sync[1:0], ser_cs};
      r_din_sync <= {r_din_sync[0], ser_data_in};
    end
  end

  // Arm frame starts only once a genuinely high cs has been seen after reset,
  // so a cs held low through reset cannot masquerade as a falling edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flushed  <= 1'b0;
      r_cs_armed <= 1'b0;
    end else begin
      r_flushed  <= 1'b1;
      r_cs_armed <= r_cs_armed | (r_flushed & r_cs_sync[0]);
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and datapath control decisions
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_shift     = 1'b0;
    w_last      = 1'b0;
    w_err       = 1'b0;
    w_busy_nxt  = busy;
    case (r_state)
      IDLE: begin
        w_busy_nxt = 1'b0;
        if (w_cs_fall && r_cs_armed) begin
          w_start     = 1'b1;
          w_busy_nxt  = 1'b1;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (w_clk_fall) begin
          w_shift = 1'b1;
          if (w_cnt_last) begin
            w_last      = 1'b1;
            w_state_nxt = WAIT_CS;
          end
        end
        // A same-cycle completing edge wins over the cs release
        if (w_cs_rise) begin
          w_busy_nxt  = 1'b0;
          w_state_nxt = IDLE;
          w_err       = ~(w_clk_fall & w_cnt_last);
        end
      end
      WAIT_CS: begin
        if (w_cs_s) begin
          w_busy_nxt  = 1'b0;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Shift registers, bit counter and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bit_cnt    <= '0;
      r_tx_shift   <= '0;
      r_rx_shift   <= '0;
      r_rx_done    <= 1'b0;
      ser_data_out <= 1'b0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      frame_err    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      r_rx_done <= w_last;
      rx_valid  <= r_rx_done;
      frame_err <= w_err;
      busy      <= w_busy_nxt;
      if (w_start) begin
        r_tx_shift   <= tx_data;
        ser_data_out <= tx_data[DATA_WIDTH-1];
        r_bit_cnt    <= '0;
      end
      if (w_shift) begin
        r_rx_shift <= {r_rx_shift[DATA_WIDTH-2:0], w_din_s};
        r_bit_cnt  <= r_bit_cnt + CNT_W'(1);
        if (w_last) begin
          rx_data <= {r_rx_shift[DATA_WIDTH-2:0], w_din_s};
        end else begin
          r_tx_shift   <= {r_tx_shift[DATA_WIDTH-2:0], 1'b0};
          ser_data_out <= r_tx_shift[DATA_WIDTH-2];
        end
      end
    end
  end

endmodule

// File: tb/tb_parallel_serial_slave.sv
// Bench for parallel_serial_slave: an 8-bit and a default-width instance share
// the serial lines; an initiator model drives frames and checks both directions.
module tb_parallel_serial_slave;

  logic         clk = 1'b0;
  logic         rst;
  logic         ser_clk;
  logic         ser_cs;
  logic         ser_data_in;
  logic [7:0]   tx8;
  logic [7:0]   rx8;
  logic         sdo8, v8, e8, b8;
  logic [170:0] tx171;
  logic [170:0] rx171;
  logic         sdo171, v171, e171, b171;

  logic         clr;
  int           cv8, ce8, cv171, ce171;
  int           n_tests = 0;
  int           n_fail  = 0;
  logic [170:0] cap;
  logic [170:0] word;

  always #5 clk = ~clk;

  parallel_serial_slave #(.DATA_WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .ser_clk(ser_clk), .ser_cs(ser_cs),
    .ser_data_in(ser_data_in), .ser_data_out(sdo8), .tx_data(tx8),
    .rx_data(rx8), .rx_valid(v8), .frame_err(e8), .busy(b8)
  );

  parallel_serial_slave u_dut171 (
    .clk(clk), .rst(rst), .ser_clk(ser_clk), .ser_cs(ser_cs),
    .ser_data_in(ser_data_in), .ser_data_out(sdo171), .tx_data(tx171),
    .rx_data(rx171), .rx_valid(v171), .frame_err(e171), .busy(b171)
  );

  // Pulse counters for rx_valid / frame_err, cleared at each frame start
  always @(posedge clk) begin
    if (clr) begin
      cv8 <= 0; ce8 <= 0; cv171 <= 0; ce171 <= 0;
    end else begin
      cv8   <= cv8   + int'(v8);
      ce8   <= ce8   + int'(e8);
      cv171 <= cv171 + int'(v171);
      ce171 <= ce171 + int'(e171);
    end
  end

  task automatic chk(input string tag, input logic [170:0] obs, input logic [170:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [170:0] rand171();
    logic [170:0] w = '0;
    for (int i = 0; i < 6; i++) w = {w[138:0], 32'($urandom)};
    return w;
  endfunction

  // Initiator: sends nedges bits of word (MSB first over width bits, junk beyond),
  // captures the slave's reply on each rising edge, then releases cs.
  task automatic run_frame(input int width, input int nedges, input logic [170:0] w,
                           input logic [170:0] txw, output logic [170:0] c);
    logic so;
    logic vv;
    c = '0;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    ser_cs = 1'b0;
    repeat (6) @(negedge clk);
    chk("busy_start", 171'(width == 8 ? b8 : b171), 171'(1));
    for (int i = 0; i < nedges; i++) begin
      ser_data_in = (i < width) ? w[width-1-i] : 1'($urandom);
      ser_clk = 1'b1;
      repeat (4) @(negedge clk);
      so = (width == 8) ? sdo8 : sdo171;
      if (i < width) c = {c[169:0], so};
      else chk("sdo_frozen", 171'(so), 171'(txw[0]));
      ser_clk = 1'b0;
      for (int k = 1; k <= 4; k++) begin
        @(negedge clk);
        if (i == width - 1) begin
          vv = (width == 8) ? v8 : v171;
          chk("rx_valid_latency", 171'(vv), 171'(k == 4));
        end
      end
    end
    ser_cs = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; ser_clk = 1'b0; ser_cs = 1'b1; ser_data_in = 1'b0; clr = 1'b1;
    tx8 = 8'hA5; tx171 = '0;
    repeat (3) @(negedge clk);
    chk("reset_rx_data", 171'(rx8), '0);
    chk("reset_rx_valid", 171'(v8), '0);
    chk("reset_frame_err", 171'(e8), '0);
    chk("reset_busy", 171'(b8), '0);
    chk("reset_sdo", 171'(sdo8), '0);
    chk("reset_rx171", rx171, '0);
    rst = 1'b0; clr = 1'b0;
    repeat (5) @(negedge clk);

    // Basic frame: receive 3C, return A5
    run_frame(8, 8, 171'(8'h3C), 171'(tx8), cap);
    chk("basic_rx", 171'(rx8), 171'(8'h3C));
    chk("basic_reply", 171'(cap[7:0]), 171'(8'hA5));
    chk("basic_valid_cnt", 171'(cv8), 171'(1));
    chk("basic_err_cnt", 171'(ce8), 171'(0));
    chk("basic_busy_end", 171'(b8), 171'(0));

    // Back-to-back frames
    run_frame(8, 8, 171'(8'hFF), 171'(tx8), cap);
    chk("b2b_rx_ff", 171'(rx8), 171'(8'hFF));
    chk("b2b_valid_ff", 171'(cv8), 171'(1));
    run_frame(8, 8, 171'(8'h01), 171'(tx8), cap);
    chk("b2b_rx_01", 171'(rx8), 171'(8'h01));
    chk("b2b_valid_01", 171'(cv8), 171'(1));
    chk("b2b_reply", 171'(cap[7:0]), 171'(8'hA5));

    // Aborted frame after 5 bits
    run_frame(8, 5, 171'(8'hC3), 171'(tx8), cap);
    chk("abort_err_cnt", 171'(ce8), 171'(1));
    chk("abort_valid_cnt", 171'(cv8), 171'(0));
    chk("abort_rx_kept", 171'(rx8), 171'(8'h01));
    chk("abort_busy", 171'(b8), 171'(0));

    // Extra clock edges with cs held low
    tx8 = 8'h3B;
    run_frame(8, 10, 171'(8'h96), 171'(tx8), cap);
    chk("extra_rx", 171'(rx8), 171'(8'h96));
    chk("extra_valid_cnt", 171'(cv8), 171'(1));
    chk("extra_reply", 171'(cap[7:0]), 171'(8'h3B));
    chk("extra_err_cnt", 171'(ce8), 171'(0));

    // Reset mid-frame, cs held low across the release
    tx8 = 8'hA5;
    ser_cs = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      ser_data_in = 1'($urandom);
      ser_clk = 1'b1; repeat (4) @(negedge clk);
      ser_clk = 1'b0; repeat (4) @(negedge clk);
    end
    chk("pre_rst_busy", 171'(b8), 171'(1));
    rst = 1'b1;
    #1;
    chk("rst_rx_data", 171'(rx8), '0);
    chk("rst_busy", 171'(b8), '0);
    chk("rst_sdo", 171'(sdo8), '0);
    chk("rst_valid", 171'(v8), '0);
    chk("rst_err", 171'(e8), '0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("rst_cs_low_no_frame", 171'(b8), '0);
    ser_cs = 1'b1;
    repeat (8) @(negedge clk);
    run_frame(8, 8, 171'(8'h5A), 171'(tx8), cap);
    chk("post_rst_rx", 171'(rx8), 171'(8'h5A));
    chk("post_rst_reply", 171'(cap[7:0]), 171'(8'hA5));

    // Full-width random frames in both directions
    for (int t = 0; t < 2; t++) begin
      tx171 = rand171();
      word  = rand171();
      run_frame(171, 171, word, tx171, cap);
      chk("w171_rx", rx171, word);
      chk("w171_reply", cap, tx171);
      chk("w171_valid_cnt", 171'(cv171), 171'(1));
      chk("w171_err_cnt", 171'(ce171), 171'(0));
      chk("w171_busy_end", 171'(b171), 171'(0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
